round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win a game; legal range 1..15.
REQ-002 Parameter SERVE_TICKS, default 1, number of tick_2s pulses to wait before each serve; legal range 1..3.
REQ-003 Port clk  input  1  system clock, 50 MHz.
REQ-004 Port rst  input  1  reset; asynchronous, active-low.
REQ-005 Port start_btn  input  1  start button level, already synchronised; only its rising edge is used.
REQ-006 Port point_left  input  1  one-cycle pulse; the left player scored.
REQ-007 Port point_right  input  1  one-cycle pulse; the right player scored.
REQ-008 Port tick_2s  input  1  one-cycle pulse from the 2-second timer.
REQ-009 Port start_counting  output  1  enable for the 2-second timer; high only in SERVE_WAIT.
REQ-010 Port ball_enable  output  1  lets the ball move; high only in PLAY.
REQ-011 Port score_left  output  4  left player's score.
REQ-012 Port score_right  output  4  right player's score.
REQ-013 Port serve_dir  output  1  serve direction: 0 = toward left, 1 = toward right.
REQ-014 Port winner  output  2  game result: 00 = none, 01 = left won, 10 = right won.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SERVE_WAIT, PLAY, OVER.
REQ-016 All outputs SHALL be registered and SHALL reflect the new state on the same clock edge that enters it.
REQ-017 IDLE: a start_btn rising edge SHALL clear both scores, clear winner, set serve_dir to 1, clear wait_cnt, and enter SERVE_WAIT.
REQ-018 SERVE_WAIT: each tick_2s SHALL increment wait_cnt; the tick that brings wait_cnt to SERVE_TICKS SHALL clear wait_cnt and enter PLAY.
REQ-019 PLAY: point_left alone SHALL increment score_left, set serve_dir to 1 (serve toward the loser), and enter SERVE_WAIT, or OVER if the new score equals WIN_SCORE.
REQ-020 PLAY: point_right alone SHALL mirror REQ-019 with score_right and serve_dir = 0.
REQ-021 point_left and point_right asserted in the same cycle SHALL be ignored; no score change, and the FSM stays in PLAY.
REQ-022 On entering OVER, winner SHALL be set to the scoring side; scores and winner SHALL then hold.
REQ-023 OVER: a start_btn rising edge SHALL behave exactly as in REQ-017.
REQ-024 Point pulses outside PLAY, tick_2s outside SERVE_WAIT, and start_btn edges in SERVE_WAIT or PLAY SHALL be ignored.
REQ-025 Holding start_btn high SHALL produce only one start; a new start requires a low-then-high transition.
REQ-026 Scores SHALL never exceed WIN_SCORE; 4-bit arithmetic with no wrap.
REQ-027 start_counting SHALL be low for at least one cycle between consecutive SERVE_WAIT visits, so that each serve gets a fresh 2-second interval.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, scores = 0, wait_cnt = 0, start_counting = 0, ball_enable = 0, serve_dir = 0, winner = 00, and the edge-detect register = 0.
REQ-029 Reset asserted mid-serve or mid-play SHALL abandon the game with no residual state.
REQ-030 After reset release, the first start_btn rising edge (low-to-high, sampled on or after release) SHALL start a game.

Structure
REQ-031 A shared package pong_pkg SHALL hold the state enum, the winner encodings, SCORE_W = 4, and the WIN_SCORE default.
REQ-032 One sub-module, rise_detect (one-flop rising-edge detector on start_btn), SHALL be instantiated; all other logic is flat.

Verification
REQ-033 Reset, then start_btn 0->1 -> next edge: SERVE_WAIT, start_counting = 1, ball_enable = 0, serve_dir = 1.
REQ-034 SERVE_TICKS = 2, two tick_2s pulses 10 cycles apart -> PLAY after the second pulse only; start_counting = 0, ball_enable = 1.
REQ-035 WIN_SCORE = 3, three point_right pulses, each followed by a serve -> score_right = 3, winner = 10, OVER, ball_enable = 0; further point pulses leave the scores unchanged.
REQ-036 In PLAY, point_left and point_right in the same cycle -> scores 0/0, still PLAY; a tick_2s pulse in PLAY -> no effect.
REQ-037 rst low while in SERVE_WAIT with score_left = 2 -> immediately IDLE, all outputs zero; start_btn held high through reset release -> no start until it goes low then high again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong round controller.
// Latency: n/a (declarations only); backpressure: n/a.
package pong_pkg;

   localparam int SCORE_W       = 4;
   localparam int WIN_SCORE_DEF = 7;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_WAIT = 2'd1,
      PLAY       = 2'd2,
      OVER       = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the start button; rise is combinational off one flop.
// Latency: same cycle; backpressure: none. A level already high at reset release is not an edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   // Remembers "button was low last cycle"; clearing it in reset blocks a held button.
   logic was_low;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         was_low <= 1'b0;
      end else begin
         was_low <= ~level;
      end
   end

   assign rise = level & was_low;

endmodule

// File: rtl/round_controller.sv
// Pong game round FSM: serve delay, scoring, winner detection; all outputs registered.
// Latency: outputs follow the state entered on the same edge; backpressure: none (pulse inputs).
module round_controller
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = WIN_SCORE_DEF,
   parameter int SERVE_TICKS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_btn,
   input  logic               point_left,
   input  logic               point_right,
   input  logic               tick_2s,
   output logic               start_counting,
   output logic               ball_enable,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic               serve_dir,
   output logic [1:0]         winner
);

   localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
   localparam logic [1:0]         SERVE_T = 2'(SERVE_TICKS);

   state_t             state, state_nxt;
   logic [SCORE_W-1:0] score_left_nxt, score_right_nxt;
   logic [1:0]         wait_cnt, wait_cnt_nxt;
   logic               serve_dir_nxt;
   logic [1:0]         winner_nxt;
   logic               start_rise;

   rise_detect u_rise_detect (
      .clk   (clk),
      .rst   (rst),
      .level (start_btn),
      .rise  (start_rise)
   );

   always_comb begin
      state_nxt       = state;
      score_left_nxt  = score_left;
      score_right_nxt = score_right;
      wait_cnt_nxt    = wait_cnt;
      serve_dir_nxt   = serve_dir;
      winner_nxt      = winner;

      case (state)
         IDLE, OVER: begin
            if (start_rise) begin
               score_left_nxt  = '0;
               score_right_nxt = '0;
               winner_nxt      = WIN_NONE;
               serve_dir_nxt   = 1'b1;
               wait_cnt_nxt    = 2'd0;
               state_nxt       = SERVE_WAIT;
            end
         end
         SERVE_WAIT: begin
            if (tick_2s) begin
               if (wait_cnt + 2'd1 == SERVE_T) begin
                  wait_cnt_nxt = 2'd0;
                  state_nxt    = PLAY;
               end else begin
                  wait_cnt_nxt = wait_cnt + 2'd1;
               end
            end
         end
         PLAY: begin
            // Simultaneous points are ambiguous and dropped; the serve goes toward the loser.
            if (point_left && !point_right) begin
               score_left_nxt = score_left + SCORE_W'(1);
               serve_dir_nxt  = 1'b1;
               if (score_left_nxt == WIN_S) begin
                  winner_nxt = WIN_LEFT;
                  state_nxt  = OVER;
               end else begin
                  state_nxt  = SERVE_WAIT;
               end
            end else if (point_right && !point_left) begin
               score_right_nxt = score_right + SCORE_W'(1);
               serve_dir_nxt   = 1'b0;
               if (score_right_nxt == WIN_S) begin
                  winner_nxt = WIN_RIGHT;
                  state_nxt  = OVER;
               end else begin
                  state_nxt  = SERVE_WAIT;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         score_left     <= '0;
         score_right    <= '0;
         wait_cnt       <= 2'd0;
         serve_dir      <= 1'b0;
         winner         <= WIN_NONE;
         start_counting <= 1'b0;
         ball_enable    <= 1'b0;
      end else begin
         state          <= state_nxt;
         score_left     <= score_left_nxt;
         score_right    <= score_right_nxt;
         wait_cnt       <= wait_cnt_nxt;
         serve_dir      <= serve_dir_nxt;
         winner         <= winner_nxt;
         // Decoded from the next state so the enables change on the entering edge.
         start_counting <= (state_nxt == SERVE_WAIT);
         ball_enable    <= (state_nxt == PLAY);
      end
   end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed vector table, reset corner cases, random run vs model.
module tb_round_controller;

   localparam int WS = 3;
   localparam int ST = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_btn = 1'b0;
   logic       point_left = 1'b0;
   logic       point_right = 1'b0;
   logic       tick_2s = 1'b0;
   logic       start_counting;
   logic       ball_enable;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic       serve_dir;
   logic [1:0] winner;

   always #10 clk = ~clk;

   round_controller #(.WIN_SCORE(WS), .SERVE_TICKS(ST)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_btn      (start_btn),
      .point_left     (point_left),
      .point_right    (point_right),
      .tick_2s        (tick_2s),
      .start_counting (start_counting),
      .ball_enable    (ball_enable),
      .score_left     (score_left),
      .score_right    (score_right),
      .serve_dir      (serve_dir),
      .winner         (winner)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: game phase plus plain integer scores.
   localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2, P_OVER = 3;
   int m_phase, m_sl, m_sr, m_ticks, m_dir, m_win;
   bit m_prev_btn;

   function void model_reset();
      m_phase = P_IDLE; m_sl = 0; m_sr = 0; m_ticks = 0; m_dir = 0; m_win = 0;
      m_prev_btn = 1'b1;
   endfunction

   function void model_step(bit b, bit pl, bit pr, bit tk);
      bit start;
      start = b && !m_prev_btn;
      m_prev_btn = b;
      if ((m_phase == P_IDLE || m_phase == P_OVER) && start) begin
         m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1; m_ticks = 0; m_phase = P_WAIT;
      end else if (m_phase == P_WAIT && tk) begin
         m_ticks++;
         if (m_ticks == ST) begin m_ticks = 0; m_phase = P_PLAY; end
      end else if (m_phase == P_PLAY && (pl != pr)) begin
         if (pl) begin
            m_sl++; m_dir = 1;
            if (m_sl == WS) begin m_win = 1; m_phase = P_OVER; end else m_phase = P_WAIT;
         end else begin
            m_sr++; m_dir = 0;
            if (m_sr == WS) begin m_win = 2; m_phase = P_OVER; end else m_phase = P_WAIT;
         end
      end
   endfunction

   function logic [12:0] model_outs();
      return {m_phase == P_WAIT, m_phase == P_PLAY, 4'(m_sl), 4'(m_sr), 1'(m_dir), 2'(m_win)};
   endfunction

   function logic [12:0] pack(bit sc, bit be, int sl, int sr, bit dir, int win);
      return {sc, be, 4'(sl), 4'(sr), dir, 2'(win)};
   endfunction

   task automatic check(input string name, input logic [12:0] exp);
      logic [12:0] act;
      act = {start_counting, ball_enable, score_left, score_right, serve_dir, winner};
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got sc/be/sl/sr/dir/win=%b/%b/%0d/%0d/%b/%b want %b/%b/%0d/%0d/%b/%b",
                    name, act[12], act[11], act[10:7], act[6:3], act[2], act[1:0],
                    exp[12], exp[11], exp[10:7], exp[6:3], exp[2], exp[1:0]);
   endtask

   // Called at a negedge: drive, take one active edge, return at the following negedge.
   task automatic step(input bit b, input bit pl, input bit pr, input bit tk);
      start_btn = b; point_left = pl; point_right = pr; tick_2s = tk;
      @(posedge clk);
      model_step(b, pl, pr, tk);
      @(negedge clk);
   endtask

   typedef struct {
      bit          b, pl, pr, tk;
      int          reps;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[19];

   function vec_t mk(bit b, bit pl, bit pr, bit tk, int reps, logic [12:0] exp);
      vec_t v;
      v.b = b; v.pl = pl; v.pr = pr; v.tk = tk; v.reps = reps; v.exp = exp;
      return v;
   endfunction

   initial begin
      //              btn pl pr tk reps        sc be sl sr dir win
      vecs[0]  = mk(0, 0, 0, 0, 2, pack(0, 0, 0, 0, 0, 0));  // idle, no start
      vecs[1]  = mk(1, 0, 0, 0, 1, pack(1, 0, 0, 0, 1, 0));  // start edge
      vecs[2]  = mk(1, 0, 0, 1, 1, pack(1, 0, 0, 0, 1, 0));  // first tick of two
      vecs[3]  = mk(0, 0, 0, 0, 9, pack(1, 0, 0, 0, 1, 0));  // still waiting
      vecs[4]  = mk(0, 0, 0, 1, 1, pack(0, 1, 0, 0, 1, 0));  // second tick -> play
      vecs[5]  = mk(0, 1, 1, 0, 1, pack(0, 1, 0, 0, 1, 0));  // both points ignored
      vecs[6]  = mk(0, 0, 0, 1, 1, pack(0, 1, 0, 0, 1, 0));  // tick in play ignored
      vecs[7]  = mk(1, 0, 0, 0, 1, pack(0, 1, 0, 0, 1, 0));  // start edge in play ignored
      vecs[8]  = mk(0, 0, 1, 0, 1, pack(1, 0, 0, 1, 0, 0));  // right scores
      vecs[9]  = mk(0, 1, 0, 0, 1, pack(1, 0, 0, 1, 0, 0));  // point in serve ignored
      vecs[10] = mk(0, 0, 0, 1, 2, pack(0, 1, 0, 1, 0, 0));
      vecs[11] = mk(0, 0, 1, 0, 1, pack(1, 0, 0, 2, 0, 0));
      vecs[12] = mk(0, 0, 0, 1, 2, pack(0, 1, 0, 2, 0, 0));
      vecs[13] = mk(0, 1, 0, 0, 1, pack(1, 0, 1, 2, 1, 0));  // left scores, serve right
      vecs[14] = mk(0, 0, 0, 1, 2, pack(0, 1, 1, 2, 1, 0));
      vecs[15] = mk(0, 0, 1, 0, 1, pack(0, 0, 1, 3, 0, 2));  // right wins
      vecs[16] = mk(0, 1, 0, 0, 1, pack(0, 0, 1, 3, 0, 2));  // over: scores hold
      vecs[17] = mk(0, 0, 1, 1, 1, pack(0, 0, 1, 3, 0, 2));
      vecs[18] = mk(1, 0, 0, 0, 1, pack(1, 0, 0, 0, 1, 0));  // restart clears

      rst = 1'b0;
      #1;
      check("reset_state", pack(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      for (int i = 0; i < 19; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) step(vecs[i].b, vecs[i].pl, vecs[i].pr, vecs[i].tk);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Build up score_left = 2 in SERVE_WAIT, then reset with the button held.
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      check("left_two_serve", pack(1, 0, 2, 0, 1, 0));
      step(1, 0, 0, 0);
      check("start_in_serve", pack(1, 0, 2, 0, 1, 0));
      rst = 1'b0;
      #1;
      check("async_reset", pack(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      check("held_btn_no_start", pack(0, 0, 0, 0, 0, 0));
      step(0, 0, 0, 0);
      check("btn_low", pack(0, 0, 0, 0, 0, 0));
      step(1, 0, 0, 0);
      check("fresh_start", pack(1, 0, 0, 0, 1, 0));

      // Random run against the model, with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b0;
            #1;
            check("rand_reset", pack(0, 0, 0, 0, 0, 0));
            @(negedge clk);
            rst = 1'b1;
            model_reset();
         end else begin
            bit b, pl, pr, tk;
            b  = ($urandom_range(0, 7) == 0) ? ~start_btn : start_btn;
            pl = ($urandom_range(0, 5) == 0);
            pr = ($urandom_range(0, 5) == 0);
            tk = ($urandom_range(0, 2) == 0);
            step(b, pl, pr, tk);
            check($sformatf("rand%0d", n), model_outs());
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
